// File: rtl/cpu_control_fsm.sv
`default_nettype none
// cpu_control_fsm: multicycle fetch/decode/exec/mem/wb sequencer with req/ack memory
// handshakes and an ack timeout that traps into HALT. Rev 1.0
module cpu_control_fsm #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       ir_wr_en,
  output logic       pc_wr_en,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic       reg_wr_en,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       halted,
  output logic       error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;

  logic       is_rtype, is_r_alu, is_bne, is_lw, is_sw, exec_legal, timed_out;
  logic       imem_req_c, dmem_req_c, dmem_we_c, ir_wr_en_c, pc_wr_en_c, reg_wr_en_c, retire_c;
  logic [1:0] pc_src_c, alu_op_c, alu_src_b_c, reg_dst_c, wb_sel_c;
  logic [1:0] ex_alu_op, ex_src_b;

  assign is_rtype   = (opcode == OP_RTYPE);
  assign is_r_alu   = is_rtype && (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT);
  assign is_bne     = (opcode == OP_BNE);
  assign is_lw      = (opcode == OP_LW);
  assign is_sw      = (opcode == OP_SW);
  assign exec_legal = is_r_alu || is_lw || is_sw || is_bne ||
                      (opcode == OP_ADDI) || (opcode == OP_XORI);
  assign timed_out  = (TIMEOUT != 0) && (cnt_q == TIMEOUT_C);

  // ALU controls chosen in EXEC and held through WB for the same instruction
  always_comb begin
    ex_alu_op = 2'd0;
    ex_src_b  = 2'd0;
    if (is_rtype) begin
      if (funct == FN_SUB)      ex_alu_op = 2'd1;
      else if (funct == FN_SLT) ex_alu_op = 2'd3;
    end else if (is_bne) begin
      ex_alu_op = 2'd1;
    end else if (opcode == OP_XORI) begin
      ex_alu_op = 2'd2;
      ex_src_b  = 2'd2;
    end else begin
      ex_src_b  = 2'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    error_d     = error_q;
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    ir_wr_en_c  = 1'b0;
    pc_wr_en_c  = 1'b0;
    pc_src_c    = 2'd0;
    alu_op_c    = 2'd0;
    alu_src_b_c = 2'd0;
    reg_wr_en_c = 1'b0;
    reg_dst_c   = 2'd0;
    wb_sel_c    = 2'd0;
    retire_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_wr_en_c = 1'b1;
          state_d    = S_DECODE;
        end else if (timed_out) begin
          state_d = S_HALT;
          error_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (opcode == OP_J || opcode == OP_JAL) begin
          pc_wr_en_c = 1'b1;
          pc_src_c   = 2'd2;
          retire_c   = 1'b1;
          state_d    = S_FETCH;
          if (opcode == OP_JAL) begin
            reg_wr_en_c = 1'b1;
            reg_dst_c   = 2'd2;
            wb_sel_c    = 2'd2;
          end
        end else if (is_rtype && funct == FN_JR) begin
          pc_wr_en_c = 1'b1;
          pc_src_c   = 2'd3;
          retire_c   = 1'b1;
          state_d    = S_FETCH;
        end else if (exec_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          error_d = 1'b1;
        end
      end
      S_EXEC: begin
        alu_op_c    = ex_alu_op;
        alu_src_b_c = ex_src_b;
        if (is_bne) begin
          pc_wr_en_c = 1'b1;
          pc_src_c   = zero ? 2'd0 : 2'd1;
          retire_c   = 1'b1;
          state_d    = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c  = 1'b1;
        dmem_we_c   = is_sw;
        alu_src_b_c = 2'd1;
        if (dmem_ack) begin
          if (is_sw) begin
            pc_wr_en_c = 1'b1;
            retire_c   = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timed_out) begin
          state_d = S_HALT;
          error_d = 1'b1;
        end
      end
      S_WB: begin
        alu_op_c    = ex_alu_op;
        alu_src_b_c = ex_src_b;
        reg_wr_en_c = 1'b1;
        reg_dst_c   = is_rtype ? 2'd1 : 2'd0;
        wb_sel_c    = is_lw ? 2'd1 : 2'd0;
        pc_wr_en_c  = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: begin
      end
      default: begin
        state_d = S_HALT;
        error_d = 1'b1;
      end
    endcase

    // Wait counter restarts on every state change and ticks while waiting for an ack
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_FETCH || state_q == S_MEM) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  // Reset masks the decoded controls combinationally so memory requests drop at once
  assign imem_req  = imem_req_c  & ~rst;
  assign dmem_req  = dmem_req_c  & ~rst;
  assign dmem_we   = dmem_we_c   & ~rst;
  assign ir_wr_en  = ir_wr_en_c  & ~rst;
  assign pc_wr_en  = pc_wr_en_c  & ~rst;
  assign reg_wr_en = reg_wr_en_c & ~rst;
  assign retire    = retire_c    & ~rst;
  assign pc_src    = rst ? 2'd0 : pc_src_c;
  assign alu_op    = rst ? 2'd0 : alu_op_c;
  assign alu_src_b = rst ? 2'd0 : alu_src_b_c;
  assign reg_dst   = rst ? 2'd0 : reg_dst_c;
  assign wb_sel    = rst ? 2'd0 : wb_sel_c;
  assign halted    = (state_q == S_HALT);
  assign error     = error_q;
  assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// Bench for cpu_control_fsm: random instruction stream against a scoreboard of expected
// retirements, then directed halt, timeout and asynchronous-reset cases.
module tb_cpu_control_fsm;

  localparam int NUM_INSTR = 80;
  localparam int BUDGET    = 4000;

  localparam int K_ADD = 0, K_SUB = 1, K_SLT = 2, K_JR = 3, K_J = 4, K_JAL = 5;
  localparam int K_BNE = 6, K_ADDI = 7, K_XORI = 8, K_LW = 9, K_SW = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, imem_ack, dmem_ack;
  logic       imem_req, dmem_req, dmem_we, ir_wr_en, pc_wr_en, reg_wr_en, retire;
  logic       halted, error;
  logic [1:0] pc_src, alu_op, alu_src_b, reg_dst, wb_sel;
  logic [2:0] state;

  cpu_control_fsm #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .ir_wr_en(ir_wr_en), .pc_wr_en(pc_wr_en), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src_b(alu_src_b), .reg_wr_en(reg_wr_en), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .retire(retire), .halted(halted), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc_src, reg_wr, reg_dst, wb_sel, alu_op, src_b, we, cycles;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;

  logic [5:0] OPC [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h05, 6'h08, 6'h0e, 6'h23, 6'h2b};
  logic [5:0] FNC [11] = '{6'h20, 6'h22, 6'h2a, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  int  cur_kind, cur_di, cur_dm, icnt, dcnt, n_retired;
  bit  cur_z, need_new, mon_run;
  int  mon_cyc, mon_stray;
  bit  mon_we;
  int  nfetch;
  exp_t e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: latency is fetch wait + the phases the instruction visits
  function automatic exp_t model(input int k, input int di, input int dm, input bit z);
    exp_t r;
    int   fetch;
    r = '{default: 0};
    fetch = di + 1;
    case (k)
      K_ADD, K_SUB, K_SLT: begin
        r.reg_wr = 1; r.reg_dst = 1;
        r.alu_op = (k == K_ADD) ? 0 : (k == K_SUB) ? 1 : 3;
        r.cycles = fetch + 3;
      end
      K_ADDI: begin r.reg_wr = 1; r.src_b = 1; r.cycles = fetch + 3; end
      K_XORI: begin r.reg_wr = 1; r.alu_op = 2; r.src_b = 2; r.cycles = fetch + 3; end
      K_JR:   begin r.pc_src = 3; r.cycles = fetch + 1; end
      K_J:    begin r.pc_src = 2; r.cycles = fetch + 1; end
      K_JAL:  begin r.pc_src = 2; r.reg_wr = 1; r.reg_dst = 2; r.wb_sel = 2; r.cycles = fetch + 1; end
      K_BNE:  begin r.pc_src = z ? 0 : 1; r.alu_op = 1; r.cycles = fetch + 2; end
      K_LW:   begin r.reg_wr = 1; r.wb_sel = 1; r.src_b = 1; r.cycles = fetch + 2 + (dm + 1) + 1; end
      default: begin r.we = 1; r.src_b = 1; r.cycles = fetch + 2 + (dm + 1); end
    endcase
    return r;
  endfunction

  // Memory responder: acks after a random number of request cycles
  task automatic drive_step();
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (imem_req) begin
      if (need_new) begin
        cur_kind = $urandom_range(0, 10);
        cur_di   = $urandom_range(0, 4);
        cur_dm   = $urandom_range(0, 4);
        cur_z    = 1'($urandom_range(0, 1));
        sb.push_back(model(cur_kind, cur_di, cur_dm, cur_z));
        need_new = 1'b0;
        icnt     = 0;
      end
      if (icnt == cur_di) begin
        imem_ack = 1'b1;
        opcode   = OPC[cur_kind];
        funct    = (cur_kind <= K_JR) ? FNC[cur_kind] : 6'($urandom);
        need_new = 1'b1;
        dcnt     = 0;
      end else begin
        icnt++;
      end
    end
    if (dmem_req) begin
      if (dcnt == cur_dm) dmem_ack = 1'b1;
      else dcnt++;
    end
    zero = (cur_kind == K_BNE) ? cur_z : 1'($urandom);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst      = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    chk("reset_state", state, 0);
    chk("reset_error", error, 0);
    chk("reset_imem_req", imem_req, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    need_new = 1'b1; n_retired = 0; cur_kind = K_ADD; cur_di = 0; cur_dm = 0; cur_z = 1'b0;
    icnt = 0; dcnt = 0; mon_cyc = 0; mon_stray = 0; mon_we = 1'b0;
    #2;
    chk("por_state", state, 0);
    chk("por_imem_req", imem_req, 0);
    chk("por_pc_wr_en", pc_wr_en, 0);
    chk("por_error", error, 0);
    chk("por_halted", halted, 0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    mon_run = 1'b1;
    #1;

    fork
      begin : monitor
        while (mon_run) begin
          @(negedge clk);
          if (mon_run && !rst) begin
            mon_cyc++;
            if (dmem_req && dmem_we) mon_we = 1'b1;
            if (reg_wr_en && !retire) mon_stray++;
            if (pc_wr_en != retire)   mon_stray++;
            if (retire) begin
              if (sb.size() == 0) begin
                chk("retire_without_instr", 1, 0);
              end else begin
                e = sb.pop_front();
                chk("pc_src", pc_src, e.pc_src);
                chk("reg_wr_en", reg_wr_en, e.reg_wr);
                chk("reg_dst", reg_dst, e.reg_dst);
                chk("wb_sel", wb_sel, e.wb_sel);
                chk("alu_op", alu_op, e.alu_op);
                chk("alu_src_b", alu_src_b, e.src_b);
                chk("dmem_we_seen", mon_we, e.we);
                chk("instr_cycles", mon_cyc, e.cycles);
                chk("stray_strobes", mon_stray, 0);
              end
              n_retired++;
              mon_cyc   = 0;
              mon_stray = 0;
              mon_we    = 1'b0;
            end
          end
        end
      end
      begin : stimulus
        int budget;
        budget = 0;
        drive_step();
        while (n_retired < NUM_INSTR && budget < BUDGET) begin
          @(posedge clk);
          #1;
          budget++;
          if (n_retired < NUM_INSTR) drive_step();
        end
        if (budget >= BUDGET) chk("random_phase_budget", n_retired, NUM_INSTR);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        mon_run  = 1'b0;
      end
    join
    chk("scoreboard_drained", sb.size(), 0);

    // Illegal opcode traps into HALT and stays there until reset
    apply_reset();
    imem_ack = 1'b1; opcode = 6'h3f; funct = 6'h00;
    #1;
    chk("illegal_ir_wr_en", ir_wr_en, 1);
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("illegal_decode", state, 1);
    @(posedge clk); #1;
    chk("illegal_halt_state", state, 5);
    chk("illegal_halted", halted, 1);
    chk("illegal_error", error, 1);
    imem_ack = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("halt_held_state", state, 5);
    chk("halt_imem_req", imem_req, 0);
    chk("halt_error_sticky", error, 1);
    imem_ack = 1'b0;

    // Unknown R-type funct also traps
    apply_reset();
    chk("after_halt_reset_halted", halted, 0);
    imem_ack = 1'b1; opcode = 6'h00; funct = 6'h21;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    chk("bad_funct_halt", state, 5);
    chk("bad_funct_error", error, 1);

    // No imem ack: HALT after exactly 16 FETCH cycles
    apply_reset();
    nfetch = 1;
    while (state == 3'd0 && nfetch < 40) begin
      @(posedge clk); #1;
      if (state == 3'd0) nfetch++;
    end
    chk("timeout_fetch_cycles", nfetch, 16);
    chk("timeout_state", state, 5);
    chk("timeout_error", error, 1);

    // Ack in the 16th FETCH cycle wins over the timeout
    apply_reset();
    repeat (15) @(posedge clk);
    #1;
    chk("ack16_still_fetch", state, 0);
    imem_ack = 1'b1; opcode = 6'h08; funct = 6'h00;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("ack16_decode", state, 1);
    chk("ack16_no_error", error, 0);

    // Reset between edges during MEM drops the data request immediately
    apply_reset();
    imem_ack = 1'b1; opcode = 6'h23; funct = 6'h00;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("lw_mem_state", state, 3);
    chk("lw_mem_req", dmem_req, 1);
    chk("lw_mem_we", dmem_we, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("midmem_rst_dmem_req", dmem_req, 0);
    chk("midmem_rst_state", state, 0);
    chk("midmem_rst_reg_wr", reg_wr_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
